// File: rtl/dvs_ravens_pkg.sv
// Shared types and constants for the DVS-to-RAVENS spike path.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package dvs_ravens_pkg;

   // DVS sensor geometry and event format
   localparam int DVS_WIDTH_PXLS  = 128;
   localparam int DVS_HEIGHT_PXLS = 128;
   localparam int DVS_X_ADDR_BITS = 7;
   localparam int DVS_Y_ADDR_BITS = 7;
   localparam int DVS_TS_BITS     = 32;
   localparam int EVENT_BITS      = DVS_X_ADDR_BITS + DVS_Y_ADDR_BITS + 1 + DVS_TS_BITS;

   // RAVENS input-spike packet fields
   localparam int RAVENS_HDR_BITS    = 3;
   localparam int RAVENS_TIME_BITS   = 16;
   localparam int RAVENS_CORE_BITS   = 4;
   localparam int RAVENS_NEURON_BITS = 4;
   localparam int RAVENS_SYN_BITS    = 5;
   localparam int RAVENS_PKT_BITS    = RAVENS_HDR_BITS + RAVENS_TIME_BITS +
                                       RAVENS_CORE_BITS + RAVENS_NEURON_BITS +
                                       RAVENS_SYN_BITS;

   typedef struct packed {
      logic [RAVENS_HDR_BITS-1:0]    hdr;
      logic [RAVENS_TIME_BITS-1:0]   tstamp;
      logic [RAVENS_CORE_BITS-1:0]   core;
      logic [RAVENS_NEURON_BITS-1:0] neuron;
      logic [RAVENS_SYN_BITS-1:0]    syn;
   } ravens_pkt_t;

   typedef struct packed {
      logic [DVS_X_ADDR_BITS-1:0] x;
      logic [DVS_Y_ADDR_BITS-1:0] y;
      logic                       pol;
      logic [DVS_TS_BITS-1:0]     ts;
   } dvs_event_t;

   // Clamp a shifted relative timestamp into the 16-bit packet time field.
   function automatic logic [RAVENS_TIME_BITS-1:0] sat_time(input logic [DVS_TS_BITS-1:0] v);
      if (|v[DVS_TS_BITS-1:RAVENS_TIME_BITS])
         return {RAVENS_TIME_BITS{1'b1}};
      else
         return v[RAVENS_TIME_BITS-1:0];
   endfunction

endpackage

// File: rtl/dvs_ravens_fifo.sv
// Synchronous first-word-fall-through FIFO; ports: push/din, pop/dout, full, empty, count.
// Latency: a pushed word is visible on dout the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together keep count.
module dvs_ravens_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage carries no reset; validity is tracked entirely by count.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)
            count <= count + CW'(1);
         else if (do_pop && !do_push)
            count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/dvs_spike_packetizer.sv
// DVS event -> RAVENS spike packet: pool, polarity split, range check, relative time, FIFO out.
// Latency: event accepted at edge k appears on out_valid/out_spike after edge k+1 (empty FIFO).
// Backpressure: in_ready drops once FIFO entries plus the staged event reach FIFO_DEPTH.
module dvs_spike_packetizer
   import dvs_ravens_pkg::*;
#(
   parameter int POOL_SHIFT_X   = 0,
   parameter int POOL_SHIFT_Y   = 0,
   parameter int POLARITY_SPLIT = 0,
   parameter int NUM_NEURONS    = 256,
   parameter int TIME_SHIFT     = 0,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [EVENT_BITS-1:0]      in_event,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       time_rebase,
   output logic [RAVENS_PKT_BITS-1:0] out_spike,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [15:0]                drop_count
);
   localparam int CW    = $clog2(FIFO_DEPTH) + 1;
   // Wide enough for the largest split index of an unpooled sensor.
   localparam int IDX_W = DVS_X_ADDR_BITS + DVS_Y_ADDR_BITS + 2;
   localparam logic [IDX_W-1:0] POOLED_W = IDX_W'(DVS_WIDTH_PXLS >> POOL_SHIFT_X);
   localparam logic [IDX_W-1:0] NN_LIMIT = IDX_W'(NUM_NEURONS);

   dvs_event_t                 s1_evt;
   logic                       s1_vld;
   logic                       accept;
   logic                       base_valid;
   logic [DVS_TS_BITS-1:0]     time_base;
   logic [IDX_W-1:0]           px;
   logic [IDX_W-1:0]           py;
   logic [IDX_W-1:0]           pix;
   logic [IDX_W-1:0]           idx;
   logic                       drop;
   logic [DVS_TS_BITS-1:0]     delta;
   ravens_pkt_t                pkt;
   logic                       fifo_push;
   logic                       fifo_pop;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic [CW-1:0]              fifo_count;
   logic [RAVENS_PKT_BITS-1:0] fifo_dout;
   logic [RAVENS_PKT_BITS-1:0] last_spike;

   // Counting the staged event guarantees stage 2 never meets a full FIFO.
   // A same-cycle pop is deliberately not credited.
   assign in_ready = (fifo_count + CW'(s1_vld)) < CW'(FIFO_DEPTH);
   assign accept   = in_valid && in_ready;

   // Stage 1: register the accepted event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld <= 1'b0;
         s1_evt <= '0;
      end else begin
         s1_vld <= accept;
         if (accept)
            s1_evt <= dvs_event_t'(in_event);
      end
   end

   // Stage 2: index, range check and relative time.
   always_comb begin
      px  = IDX_W'(s1_evt.x) >> POOL_SHIFT_X;
      py  = IDX_W'(s1_evt.y) >> POOL_SHIFT_Y;
      pix = px + py * POOLED_W;
      if (POLARITY_SPLIT != 0)
         idx = {pix[IDX_W-2:0], s1_evt.pol};
      else
         idx = pix;
      drop  = (idx >= NN_LIMIT);
      // Modulo subtraction handles timestamp wrap.
      delta = s1_evt.ts - time_base;
      pkt.hdr    = '0;
      pkt.tstamp = base_valid ? sat_time(delta >> TIME_SHIFT) : '0;
      pkt.core   = idx[7:4];
      pkt.neuron = idx[3:0];
      pkt.syn    = '0;
   end

   assign fifo_push = s1_vld && !drop && !fifo_full;
   assign fifo_pop  = out_valid && out_ready;

   // A rebase pulse invalidates the base after any event already in stage 2,
   // so an event accepted alongside the pulse reaches stage 2 with no base
   // and becomes the new base itself. Dropped events also seed the base.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_valid <= 1'b0;
         time_base  <= '0;
         drop_count <= '0;
      end else begin
         if (time_rebase) begin
            base_valid <= 1'b0;
            time_base  <= '0;
         end else if (s1_vld && !base_valid) begin
            base_valid <= 1'b1;
            time_base  <= s1_evt.ts;
         end
         if (s1_vld && drop && (drop_count != 16'hFFFF))
            drop_count <= drop_count + 16'd1;
      end
   end

   dvs_ravens_fifo #(
      .WIDTH (RAVENS_PKT_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .din   (pkt),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Keep the last delivered packet on out_spike while the FIFO is empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_spike <= '0;
      else if (fifo_pop)
         last_spike <= fifo_dout;
   end

   assign out_valid = !fifo_empty;
   assign out_spike = fifo_empty ? last_spike : fifo_dout;

endmodule

// File: tb/tb_dvs_spike_packetizer.sv
// Directed bench for dvs_spike_packetizer over three parameter sets sharing one clock/reset.
// Latency: expects packets one cycle after acceptance.
// Backpressure: exercises FIFO full with out_ready low, then drains in order.
module tb_dvs_spike_packetizer;
   import dvs_ravens_pkg::*;

   logic clk;
   logic rst_n;

   // Instance A: defaults. B: pooled, split, time-scaled. C: 16 neurons, depth 4.
   logic [EVENT_BITS-1:0]      a_in_event, b_in_event, c_in_event;
   logic                       a_in_valid, b_in_valid, c_in_valid;
   logic                       a_in_ready, b_in_ready, c_in_ready;
   logic                       a_rebase, b_rebase, c_rebase;
   logic [RAVENS_PKT_BITS-1:0] a_out_spike, b_out_spike, c_out_spike;
   logic                       a_out_valid, b_out_valid, c_out_valid;
   logic                       a_out_ready, b_out_ready, c_out_ready;
   logic [15:0]                a_drop, b_drop, c_drop;

   int vectors;
   int miscompares;
   int n_acc;

   dvs_spike_packetizer u_a (
      .clk(clk), .rst_n(rst_n), .in_event(a_in_event), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .time_rebase(a_rebase), .out_spike(a_out_spike),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .drop_count(a_drop));

   dvs_spike_packetizer #(.POOL_SHIFT_X(1), .POLARITY_SPLIT(1), .TIME_SHIFT(2)) u_b (
      .clk(clk), .rst_n(rst_n), .in_event(b_in_event), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .time_rebase(b_rebase), .out_spike(b_out_spike),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .drop_count(b_drop));

   dvs_spike_packetizer #(.NUM_NEURONS(16), .FIFO_DEPTH(4)) u_c (
      .clk(clk), .rst_n(rst_n), .in_event(c_in_event), .in_valid(c_in_valid),
      .in_ready(c_in_ready), .time_rebase(c_rebase), .out_spike(c_out_spike),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .drop_count(c_drop));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [EVENT_BITS-1:0] ev(input logic [6:0] x, input logic [6:0] y,
                                                input logic pol, input logic [31:0] ts);
      dvs_event_t e;
      e.x = x; e.y = y; e.pol = pol; e.ts = ts;
      return e;
   endfunction

   function automatic logic [31:0] exp_pkt(input logic [15:0] t, input logic [7:0] idx);
      return {3'b000, t, idx[7:4], idx[3:0], 5'b00000};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one event for one cycle, then wait until its packet would be visible.
   task automatic a_send(input logic [6:0] x, input logic [6:0] y, input logic pol,
                         input logic [31:0] ts, input logic rb);
      a_in_event = ev(x, y, pol, ts); a_in_valid = 1'b1; a_rebase = rb;
      tick();
      a_in_valid = 1'b0; a_rebase = 1'b0;
      tick();
   endtask

   task automatic b_send(input logic [6:0] x, input logic [6:0] y, input logic pol,
                         input logic [31:0] ts);
      b_in_event = ev(x, y, pol, ts); b_in_valid = 1'b1;
      tick();
      b_in_valid = 1'b0;
      tick();
   endtask

   initial begin
      vectors = 0; miscompares = 0; n_acc = 0;
      rst_n = 1'b0;
      a_in_event = '0; b_in_event = '0; c_in_event = '0;
      a_in_valid = 0; b_in_valid = 0; c_in_valid = 0;
      a_rebase = 0; b_rebase = 0; c_rebase = 0;
      a_out_ready = 1; b_out_ready = 1; c_out_ready = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // Reset state
      chk("rst_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst_out_spike", a_out_spike, 32'd0);
      chk("rst_drop", 32'(a_drop), 32'd0);
      chk("rst_in_ready", 32'(a_in_ready), 32'd1);
      chk("rst_in_ready_c", 32'(c_in_ready), 32'd1);

      // Basic mapping: x=17 -> core 1 neuron 1, first event time 0
      a_send(7'd17, 7'd0, 1'b0, 32'd1000, 1'b0);
      chk("a_first_valid", 32'(a_out_valid), 32'd1);
      chk("a_first_pkt", a_out_spike, exp_pkt(16'd0, 8'd17));
      chk("a_first_drop", 32'(a_drop), 32'd0);

      // Timestamp wrap and saturation
      a_send(7'd1, 7'd0, 1'b0, 32'hFFFF_FFF0, 1'b1);
      chk("wrap_base", a_out_spike, exp_pkt(16'd0, 8'd1));
      a_send(7'd2, 7'd0, 1'b0, 32'h0000_0010, 1'b0);
      chk("wrap_delta", a_out_spike, exp_pkt(16'd32, 8'd2));
      a_send(7'd3, 7'd0, 1'b0, 32'h000F_FFF0, 1'b0);
      chk("wrap_sat", a_out_spike, exp_pkt(16'hFFFF, 8'd3));

      // Rebase coincident with acceptance
      a_send(7'd4, 7'd0, 1'b0, 32'd500, 1'b1);
      chk("rebase_zero", a_out_spike, exp_pkt(16'd0, 8'd4));
      a_send(7'd5, 7'd0, 1'b0, 32'd530, 1'b0);
      chk("rebase_next", a_out_spike, exp_pkt(16'd30, 8'd5));
      // Row stride: y=1 -> idx 131
      a_send(7'd3, 7'd1, 1'b0, 32'd600, 1'b0);
      chk("a_row_idx", a_out_spike, exp_pkt(16'd100, 8'd131));

      // Pooling + polarity split + time shift
      b_send(7'd5, 7'd0, 1'b1, 32'd1000);
      chk("b_first_pkt", b_out_spike, exp_pkt(16'd0, 8'd5));
      b_send(7'd5, 7'd0, 1'b1, 32'd1040);
      chk("b_second_pkt", b_out_spike, exp_pkt(16'd10, 8'd5));
      b_send(7'd5, 7'd1, 1'b0, 32'd1100);
      chk("b_row_pol0", b_out_spike, exp_pkt(16'd25, 8'd132));

      // Out-of-range drop
      c_in_event = ev(7'd20, 7'd0, 1'b0, 32'd0); c_in_valid = 1'b1;
      tick();
      c_in_valid = 1'b0;
      tick();
      chk("drop_no_valid", 32'(c_out_valid), 32'd0);
      chk("drop_count_1", 32'(c_drop), 32'd1);

      // Saturation of drop counter
      c_in_valid = 1'b1;
      repeat (70000) @(posedge clk);
      #1;
      c_in_valid = 1'b0;
      repeat (2) tick();
      chk("drop_sat", 32'(c_drop), 32'h0000_FFFF);
      chk("drop_sat_no_valid", 32'(c_out_valid), 32'd0);

      // Fill depth-4 FIFO with out_ready low
      for (int i = 0; i < 8; i++) begin
         c_in_event = ev(7'(i + 1), 7'd0, 1'b0, 32'(10 * i));
         c_in_valid = 1'b1;
         if (c_in_ready) n_acc++;
         tick();
      end
      c_in_valid = 1'b0;
      chk("full_accepted", 32'(n_acc), 32'd4);
      chk("full_in_ready", 32'(c_in_ready), 32'd0);
      chk("full_out_valid", 32'(c_out_valid), 32'd1);

      // Drain in order
      c_out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         chk("drain_valid", 32'(c_out_valid), 32'd1);
         chk("drain_pkt", c_out_spike, exp_pkt(16'(10 * j), 8'(j + 1)));
         tick();
      end
      chk("drain_empty", 32'(c_out_valid), 32'd0);
      chk("drain_in_ready", 32'(c_in_ready), 32'd1);
      chk("empty_hold", c_out_spike, exp_pkt(16'd30, 8'd4));

      // Reset with queued packets
      a_out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         a_in_event = ev(7'(7 + k), 7'd0, 1'b0, 32'd900);
         a_in_valid = 1'b1;
         tick();
      end
      a_in_valid = 1'b0;
      tick();
      chk("queued_valid", 32'(a_out_valid), 32'd1);
      chk("queued_head", a_out_spike, exp_pkt(16'd400, 8'd7));
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(a_out_valid), 32'd0);
      chk("midrst_spike", a_out_spike, 32'd0);
      chk("midrst_drop_c", 32'(c_drop), 32'd0);
      tick();
      rst_n = 1'b1;
      a_out_ready = 1'b1;
      repeat (3) tick();
      chk("post_rst_no_stale", 32'(a_out_valid), 32'd0);
      a_send(7'd6, 7'd0, 1'b0, 32'd777, 1'b0);
      chk("post_rst_newbase", a_out_spike, exp_pkt(16'd0, 8'd6));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
